// File: rtl/k054539_pkg.sv
// k054539_pkg: shared FSM states, default bus timing and register-address mapping
package k054539_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_CSLOW,
    ST_STROBE,
    ST_HOLD,
    ST_RECOV
  } state_t;

  localparam int CNT_W = 16;

  localparam int DEF_SETUP_CYC    = 1;
  localparam int DEF_CS2STB_CYC   = 1;
  localparam int DEF_STROBE_CYC   = 8;
  localparam int DEF_HOLD_CYC     = 1;
  localparam int DEF_RECOV_CYC    = 2;
  localparam int DEF_WAIT_TIMEOUT = 255;

  // Register bit 8 has no pin; bit 9 lands on AB09, packed here as bus bit 8.
  localparam logic [9:0] AB_LOW_MASK = 10'h0FF;
  localparam logic [9:0] AB09_MASK   = 10'h100;

  function automatic logic [8:0] bus_addr(input logic [9:0] a);
    return 9'(((a >> 1) & AB09_MASK) | (a & AB_LOW_MASK));
  endfunction

endpackage

// File: rtl/k054539_cyc_timer.sv
// k054539_cyc_timer: loadable saturating down-counter with a zero flag
module k054539_cyc_timer
  import k054539_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // load wins over decrement; the count parks at zero
  always_comb cnt_d = load_i ? val_i : (dec_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;

  // count register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

  assign zero_o = cnt_q == '0;

endmodule

// File: rtl/k054539_host_master.sv
// k054539_host_master: valid/ready request stream to 054539 host-bus cycles with WAIT handling
module k054539_host_master
  import k054539_pkg::*;
#(
  parameter int SETUP_CYC    = DEF_SETUP_CYC,
  parameter int CS2STB_CYC   = DEF_CS2STB_CYC,
  parameter int STROBE_CYC   = DEF_STROBE_CYC,
  parameter int HOLD_CYC     = DEF_HOLD_CYC,
  parameter int RECOV_CYC    = DEF_RECOV_CYC,
  parameter int WAIT_TIMEOUT = DEF_WAIT_TIMEOUT
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_WR,
  input  logic [9:0] REQ_ADDR,
  input  logic [7:0] REQ_DATA,
  output logic       RSP_VALID,
  output logic       RSP_WR,
  output logic [7:0] RSP_DATA,
  output logic       RSP_ERR,
  output logic [7:0] PIN_AB,
  output logic       PIN_AB09,
  output logic [7:0] PIN_DB_OUT,
  output logic       PIN_DB_OE,
  input  logic [7:0] PIN_DB_IN,
  output logic       PIN_NCS,
  output logic       PIN_NRD,
  output logic       PIN_NWR,
  input  logic       PIN_WAIT
);

  state_t           state_q, state_d;
  logic             wr_q, wr_d;
  logic [8:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             rsp_q, rsp_d;
  logic             ph_load, ph_zero;
  logic [CNT_W-1:0] ph_val;
  logic             wt_load, wt_dec, wt_zero;

  k054539_cyc_timer #(.W(CNT_W)) u_phase (
    .clk   (CLK),
    .rst   (RES),
    .load_i(ph_load),
    .dec_i (1'b1),
    .val_i (ph_val),
    .zero_o(ph_zero)
  );

  k054539_cyc_timer #(.W(CNT_W)) u_wait (
    .clk   (CLK),
    .rst   (RES),
    .load_i(wt_load),
    .dec_i (wt_dec),
    .val_i (CNT_W'(WAIT_TIMEOUT)),
    .zero_o(wt_zero)
  );

  // phase sequencing: each state loads its length on entry and leaves when the phase count hits zero
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    rdata_d = (state_q == ST_STROBE) ? PIN_DB_IN : rdata_q;
    ph_load = 1'b0;
    ph_val  = '0;
    wt_load = 1'b0;
    wt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: if (REQ_VALID) begin
        state_d = ST_SETUP;
        ph_load = 1'b1;
        ph_val  = CNT_W'(SETUP_CYC - 1);
        wr_d    = REQ_WR;
        addr_d  = bus_addr(REQ_ADDR);
        data_d  = REQ_WR ? REQ_DATA : '0;
      end
      ST_SETUP: if (ph_zero) begin
        state_d = ST_CSLOW;
        ph_load = 1'b1;
        ph_val  = CNT_W'(CS2STB_CYC - 1);
      end
      ST_CSLOW: if (ph_zero) begin
        state_d = ST_STROBE;
        ph_load = 1'b1;
        ph_val  = CNT_W'(STROBE_CYC - 1);
        wt_load = 1'b1;
        err_d   = 1'b0;
      end
      ST_STROBE: if (ph_zero) begin
        if (PIN_WAIT || wt_zero) begin
          state_d = ST_HOLD;
          ph_load = 1'b1;
          ph_val  = CNT_W'(HOLD_CYC - 1);
          err_d   = !PIN_WAIT;
        end else begin
          wt_dec = 1'b1;
        end
      end
      ST_HOLD: if (ph_zero) begin
        state_d = ST_RECOV;
        ph_load = 1'b1;
        ph_val  = CNT_W'(RECOV_CYC - 1);
      end
      ST_RECOV: if (ph_zero) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    rsp_d = (state_q == ST_HOLD) && (state_d == ST_RECOV);
  end

  // state and latched access registers; reset drops any access in flight
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      rsp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      rsp_q   <= rsp_d;
    end
  end

  assign REQ_READY  = (state_q == ST_IDLE) && !RES;
  assign PIN_AB     = addr_q[7:0];
  assign PIN_AB09   = addr_q[8];
  assign PIN_DB_OUT = data_q;
  assign PIN_DB_OE  = wr_q && (state_q inside {ST_SETUP, ST_CSLOW, ST_STROBE, ST_HOLD});
  assign PIN_NCS    = !(state_q inside {ST_CSLOW, ST_STROBE, ST_HOLD});
  assign PIN_NWR    = !((state_q == ST_STROBE) && wr_q);
  assign PIN_NRD    = !((state_q == ST_STROBE) && !wr_q);
  assign RSP_VALID  = rsp_q;
  assign RSP_WR     = rsp_q && wr_q;
  assign RSP_DATA   = (rsp_q && !wr_q) ? rdata_q : '0;
  assign RSP_ERR    = rsp_q && err_q;

endmodule

// File: tb/tb_k054539_host_master.sv
// tb_k054539_host_master: randomized scoreboard bench for the 054539 host-bus initiator
module tb_k054539_host_master;

  localparam int TMO   = 4;
  localparam int SCYC  = 8;
  localparam int RECOV = 2;

  logic       CLK = 1'b0, RES = 1'b1;
  logic       REQ_VALID = 1'b0, REQ_WR = 1'b0;
  logic [9:0] REQ_ADDR = '0;
  logic [7:0] REQ_DATA = '0, PIN_DB_IN = '0;
  logic       PIN_WAIT = 1'b1;
  logic       REQ_READY, RSP_VALID, RSP_WR, RSP_ERR;
  logic [7:0] RSP_DATA, PIN_AB, PIN_DB_OUT;
  logic       PIN_AB09, PIN_DB_OE, PIN_NCS, PIN_NRD, PIN_NWR;

  k054539_host_master #(.WAIT_TIMEOUT(TMO)) dut (
    .CLK(CLK), .RES(RES),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WR(REQ_WR),
    .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .RSP_VALID(RSP_VALID), .RSP_WR(RSP_WR), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
    .PIN_AB(PIN_AB), .PIN_AB09(PIN_AB09), .PIN_DB_OUT(PIN_DB_OUT), .PIN_DB_OE(PIN_DB_OE),
    .PIN_DB_IN(PIN_DB_IN), .PIN_NCS(PIN_NCS), .PIN_NRD(PIN_NRD), .PIN_NWR(PIN_NWR),
    .PIN_WAIT(PIN_WAIT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       wr;
    logic [9:0] addr;
    logic [7:0] data;
    int         len;
    logic       err;
    logic [7:0] rdata;
  } exp_t;

  exp_t       sbq[$];
  logic       wlo[64];
  logic [7:0] dbp[64];
  int         total = 0, passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  // wait pattern per strobe cycle (1-based): 0 never low, 1 low in [s, s+l), 2 always low
  task automatic set_pat(input int mode, input int s, input int l);
    for (int k = 0; k < 64; k++) begin
      wlo[k] = (mode == 2) ? 1'b1 : (mode == 1) ? (k >= s && k < s + l) : 1'b0;
      dbp[k] = 8'($urandom);
    end
  endtask

  // strobe ends at the first cycle past the minimum where WAIT is high or the extension budget is spent
  function automatic exp_t model(input logic wr, input logic [9:0] addr, input logic [7:0] data);
    exp_t e;
    int l;
    l = SCYC;
    while (wlo[l] && (l - SCYC) < TMO) l++;
    e.wr = wr; e.addr = addr; e.data = data; e.len = l;
    e.err = wlo[l];
    e.rdata = dbp[l];
    return e;
  endfunction

  task automatic send(input logic wr, input logic [9:0] addr, input logic [7:0] data, input logic hold);
    int   n;
    exp_t e;
    REQ_WR = wr; REQ_ADDR = addr; REQ_DATA = data; REQ_VALID = 1'b1;
    n = 0;
    while (!REQ_READY && n < 100) begin @(negedge CLK); n++; end
    if (!REQ_READY) begin
      chk("accept_timeout", 32'd0, 32'd1);
      REQ_VALID = 1'b0;
      return;
    end
    e = model(wr, addr, data);
    sbq.push_back(e);
    @(negedge CLK);
    if (!hold) REQ_VALID = 1'b0;
    n = 0;
    while (!REQ_READY && n < 200) begin n++; @(negedge CLK); end
    chk("ready_gap", n, 32'(5 + e.len));
  endtask

  task automatic idle(input int n);
    REQ_VALID = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  // chip model: WAIT and read data follow the current access pattern while a strobe is low
  initial begin
    int sc;
    sc = 0;
    forever @(negedge CLK) begin
      if (!PIN_NRD || !PIN_NWR) begin
        if (sc < 63) sc++;
        PIN_WAIT  = !wlo[sc];
        PIN_DB_IN = dbp[sc];
      end else begin
        sc = 0;
        PIN_WAIT  = 1'($urandom);
        PIN_DB_IN = 8'($urandom);
      end
    end
  end

  // monitor: gathers bus observations per access and checks them against the scoreboard on each response
  initial begin
    exp_t       e;
    int         slen, ncs_hi;
    logic [8:0] ab;
    logic [7:0] dbo;
    logic       sawrd, sawwr, oe_any, oe_bad, bad, gap_bad, had_acc;
    slen = 0; ncs_hi = 0; ab = '0; dbo = '0;
    sawrd = 0; sawwr = 0; oe_any = 0; oe_bad = 0; bad = 0; gap_bad = 0; had_acc = 0;
    forever @(negedge CLK) begin
      if (RES) begin
        slen = 0; ncs_hi = 0; sawrd = 0; sawwr = 0;
        oe_any = 0; oe_bad = 0; bad = 0; gap_bad = 0; had_acc = 0;
        continue;
      end
      if (!PIN_NRD && !PIN_NWR) bad = 1;
      if ((!PIN_NRD || !PIN_NWR) && PIN_NCS) bad = 1;
      if (PIN_DB_OE) oe_any = 1;
      if (!PIN_NRD || !PIN_NWR) begin
        slen++;
        ab = {PIN_AB09, PIN_AB};
        dbo = PIN_DB_OUT;
        sawrd |= !PIN_NRD;
        sawwr |= !PIN_NWR;
        if (!PIN_NWR && !PIN_DB_OE) oe_bad = 1;
      end
      if (!PIN_NCS) begin
        if (ncs_hi > 0 && had_acc && ncs_hi < RECOV) gap_bad = 1;
        ncs_hi = 0;
        had_acc = 1;
      end else begin
        ncs_hi++;
      end
      if (RSP_VALID) begin
        if (sbq.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("rsp_wr", RSP_WR, e.wr);
          chk("rsp_err", RSP_ERR, e.err);
          chk("rsp_data", RSP_DATA, e.wr ? 8'h00 : e.rdata);
          chk("strobe_len", slen, e.len);
          chk("bus_addr", ab, {e.addr[9], e.addr[7:0]});
          chk("strobe_sel", {sawwr, sawrd}, e.wr ? 2'b10 : 2'b01);
          chk("db_oe", e.wr ? (oe_any && !oe_bad) : !oe_any, 1);
          if (e.wr) chk("db_out", dbo, e.data);
          chk("strobe_rules", bad, 0);
          chk("ncs_recovery", gap_bad, 0);
        end
        slen = 0; sawrd = 0; sawwr = 0; oe_any = 0; oe_bad = 0; bad = 0; gap_bad = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    set_pat(0, 0, 0);
    repeat (3) @(negedge CLK);
    chk("rst_ready", REQ_READY, 0);
    chk("rst_ncs", PIN_NCS, 1);
    chk("rst_nrd", PIN_NRD, 1);
    chk("rst_nwr", PIN_NWR, 1);
    chk("rst_oe", PIN_DB_OE, 0);
    chk("rst_ab", {PIN_AB09, PIN_AB}, 0);
    chk("rst_dbout", PIN_DB_OUT, 0);
    chk("rst_rsp", {RSP_VALID, RSP_WR, RSP_ERR, RSP_DATA}, 0);
    RES = 1'b0;
    @(negedge CLK);
    chk("ready_after_rst", REQ_READY, 1);

    set_pat(0, 0, 0);
    send(1'b1, 10'h050, 8'h11, 1'b0);
    set_pat(0, 0, 0);
    send(1'b1, 10'h227, 8'hFC, 1'b1);
    set_pat(0, 0, 0);
    send(1'b1, 10'h22F, 8'h20, 1'b0);
    set_pat(0, 0, 0);
    for (int k = 0; k < 64; k++) dbp[k] = 8'h5A;
    send(1'b0, 10'h21B, 8'h00, 1'b0);
    set_pat(1, 6, 5);
    dbp[11] = 8'h33;
    send(1'b0, 10'h1C4, 8'h00, 1'b0);
    set_pat(2, 0, 0);
    send(1'b1, 10'h3F0, 8'hA5, 1'b0);
    idle(2);

    set_pat(0, 0, 0);
    REQ_WR = 1'b1; REQ_ADDR = 10'h0AA; REQ_DATA = 8'h99; REQ_VALID = 1'b1;
    n = 0;
    while (!REQ_READY && n < 50) begin @(negedge CLK); n++; end
    @(negedge CLK);
    REQ_VALID = 1'b0;
    n = 0;
    while (PIN_NWR && n < 50) begin @(negedge CLK); n++; end
    chk("abort_reach_strobe", PIN_NWR, 0);
    repeat (2) @(negedge CLK);
    RES = 1'b1;
    @(negedge CLK);
    chk("abort_ncs", PIN_NCS, 1);
    chk("abort_nwr", PIN_NWR, 1);
    chk("abort_nrd", PIN_NRD, 1);
    chk("abort_oe", PIN_DB_OE, 0);
    chk("abort_rsp", RSP_VALID, 0);
    chk("abort_ready", REQ_READY, 0);
    @(negedge CLK);
    RES = 1'b0;
    @(negedge CLK);
    chk("abort_ready_back", REQ_READY, 1);
    set_pat(0, 0, 0);
    send(1'b1, 10'h051, 8'h22, 1'b0);

    for (int i = 0; i < 40; i++) begin
      set_pat(int'($urandom_range(0, 2)), int'($urandom_range(1, 12)), int'($urandom_range(1, 8)));
      send(1'($urandom), 10'($urandom), 8'($urandom), 1'($urandom));
    end
    idle(20);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
